seg7_bank: RTL and testbench

SEG7_BANK -- requirements
Module: seg7_bank

---
 rtl/seg7_bank_if.sv | 35 +++
 rtl/seg7_bank.sv | 176 +++++++++++++++++
 tb/tb_seg7_bank.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_bank_if.sv
// Handshake and result bundle for seg7_bank: conversion request in, BCD/segment result out.
interface seg7_bank_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WIDTH  = 14
);
   logic                  start;
   logic [WIDTH-1:0]      value;
   logic                  busy;
   logic                  done;
   logic                  ovf;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   segments;

   // Requester side: issues start/value, observes results
   modport master (
      output start,
      output value,
      input  busy,
      input  done,
      input  ovf,
      input  bcd,
      input  segments
   );

   // Converter side
   modport slave (
      input  start,
      input  value,
      output busy,
      output done,
      output ovf,
      output bcd,
      output segments
   );
endinterface

// File: rtl/seg7_bank.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) driving a bank of
// active-low seven-segment digit patterns with optional leading-zero blanking and overflow dashes.
module seg7_bank #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned WIDTH    = 14,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   seg7_bank_if.slave bus
);

   localparam int unsigned AccW = 4 * DIGITS + 4;
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   localparam logic [6:0] SegBlank = 7'b1111111;
   localparam logic [6:0] SegDash  = 7'b0111111;

   function automatic logic [63:0] f_pow10(input int unsigned n);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam logic [63:0]     MaxVal      = f_pow10(DIGITS) - 64'd1;
   localparam logic [63:0]     InMax       = (64'd1 << WIDTH) - 64'd1;
   // A narrow input can never exceed the display range, so overflow stays tied low
   localparam bit              OvfPossible = (InMax > MaxVal);
   localparam logic [CntW-1:0] CntLast     = CntW'(WIDTH - 1);

   // Active-low gfedcba; anything above 9 shows blank
   function automatic logic [6:0] f_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0011000;
         default: s = SegBlank;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StConv = 2'd1,
      StLoad = 2'd2
   } state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [WIDTH-1:0]      r_val;
   logic [AccW-1:0]       r_acc;
   logic [CntW-1:0]       r_cnt;
   logic                  r_ovf_cap;
   logic                  r_done;
   logic                  r_ovf;
   logic [4*DIGITS-1:0]   r_bcd;
   logic [7*DIGITS-1:0]   r_seg;

   logic                  w_ovf_cap;
   logic [AccW-1:0]       w_adj;
   logic [4*DIGITS-1:0]   w_bcd_next;
   logic [7*DIGITS-1:0]   w_seg_next;
   logic                  w_lead;
   logic [3:0]            w_nib;

   assign w_ovf_cap = OvfPossible && (64'(bus.value) > MaxVal);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; start only matters in IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (bus.start) w_state_next = StConv;
         StConv:  if (r_cnt == CntLast) w_state_next = StLoad;
         StLoad:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Double-dabble correction: add 3 to every nibble >= 5 before the shift
   always_comb begin
      w_adj = r_acc;
      for (int k = 0; k <= int'(DIGITS); k++) begin
         if (r_acc[4*k +: 4] >= 4'd5) begin
            w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
         end
      end
   end

   // Result formatting from the finished accumulator: dashes on overflow, else digits with
   // leading zeros above digit 0 optionally blanked
   always_comb begin
      w_bcd_next = r_ovf_cap ? '1 : r_acc[4*DIGITS-1:0];
      w_seg_next = '1;
      w_lead     = 1'b1;
      w_nib      = 4'd0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         w_nib = r_acc[4*k +: 4];
         if (w_nib != 4'd0) begin
            w_lead = 1'b0;
         end
         if (r_ovf_cap) begin
            w_seg_next[7*k +: 7] = SegDash;
         end else if ((BLANK_LZ == 1) && w_lead && (k > 0)) begin
            w_seg_next[7*k +: 7] = SegBlank;
         end else begin
            w_seg_next[7*k +: 7] = f_seg(w_nib);
         end
      end
   end

   // Datapath: capture in IDLE, shift in CONV, publish results in LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val     <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf_cap <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_bcd     <= '0;
         r_seg     <= '1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (bus.start) begin
                  r_val     <= bus.value;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_ovf_cap <= w_ovf_cap;
               end
            end
            StConv: begin
               r_acc <= {w_adj[AccW-2:0], r_val[WIDTH-1]};
               r_val <= r_val << 1;
               r_cnt <= r_cnt + CntW'(1);
            end
            StLoad: begin
               r_bcd  <= w_bcd_next;
               r_seg  <= w_seg_next;
               r_ovf  <= r_ovf_cap;
               r_done <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy     = (r_state == StConv) || (r_state == StLoad);
   assign bus.done     = r_done;
   assign bus.ovf      = r_ovf;
   assign bus.bcd      = r_bcd;
   assign bus.segments = r_seg;

endmodule

// File: tb/tb_seg7_bank.sv
// Directed bench for seg7_bank at DIGITS=4, WIDTH=14, BLANK_LZ=1.
module tb_seg7_bank;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0011000;
   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] SD = 7'b0111111;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   seg7_bank_if #(.DIGITS(4), .WIDTH(14)) bus_if ();

   seg7_bank #(
      .DIGITS   (4),
      .WIDTH    (14),
      .BLANK_LZ (1)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a one-cycle start and return how many edges later done appeared (-1 on timeout)
   task automatic run_conv(input logic [13:0] v, output int lat);
      bus_if.value = v;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (bus_if.done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus_if.start = 1'b0;
      bus_if.value = '0;
      tick();
      tick();
      n_total++;
      if ({bus_if.busy, bus_if.done, bus_if.ovf} !== 3'b000)
         $display("FAIL reset_flags: busy/done/ovf=%b required 000",
                  {bus_if.busy, bus_if.done, bus_if.ovf});
      else n_pass++;
      n_total++;
      if (bus_if.bcd !== 16'h0000) $display("FAIL reset_bcd: got %h required 0000", bus_if.bcd);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {4{SB}})
         $display("FAIL reset_seg: got %b required all ones", bus_if.segments);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      n_total++;
      if (bus_if.segments !== {4{SB}} || bus_if.busy !== 1'b0)
         $display("FAIL reset_hold: seg=%b busy=%b required blank/0", bus_if.segments, bus_if.busy);
      else n_pass++;
   endtask

   task automatic test_1234();
      int lat;
      run_conv(14'd1234, lat);
      n_total++;
      if (lat != 15) $display("FAIL v1234_latency: got %0d required 15", lat);
      else n_pass++;
      n_total++;
      if (bus_if.bcd !== 16'h1234) $display("FAIL v1234_bcd: got %h required 1234", bus_if.bcd);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {S1, S2, S3, S4})
         $display("FAIL v1234_seg: got %b required %b", bus_if.segments, {S1, S2, S3, S4});
      else n_pass++;
      n_total++;
      if (bus_if.ovf !== 1'b0 || bus_if.busy !== 1'b0)
         $display("FAIL v1234_flags: ovf=%b busy=%b required 0/0", bus_if.ovf, bus_if.busy);
      else n_pass++;
      tick();
      n_total++;
      if (bus_if.done !== 1'b0) $display("FAIL v1234_pulse: done=%b required 0", bus_if.done);
      else n_pass++;
   endtask

   task automatic test_zero();
      int lat;
      run_conv(14'd0, lat);
      n_total++;
      if (lat != 15 || bus_if.bcd !== 16'h0000)
         $display("FAIL v0_bcd: lat=%0d bcd=%h required 15/0000", lat, bus_if.bcd);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {SB, SB, SB, S0})
         $display("FAIL v0_seg: got %b required %b", bus_if.segments, {SB, SB, SB, S0});
      else n_pass++;
   endtask

   task automatic test_range_edge();
      int lat;
      run_conv(14'd9999, lat);
      n_total++;
      if (lat != 15 || bus_if.bcd !== 16'h9999 || bus_if.ovf !== 1'b0)
         $display("FAIL v9999: lat=%0d bcd=%h ovf=%b required 15/9999/0",
                  lat, bus_if.bcd, bus_if.ovf);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {4{S9}})
         $display("FAIL v9999_seg: got %b required %b", bus_if.segments, {4{S9}});
      else n_pass++;
      run_conv(14'd10000, lat);
      n_total++;
      if (lat != 15 || bus_if.ovf !== 1'b1 || bus_if.bcd !== 16'hFFFF)
         $display("FAIL v10000: lat=%0d ovf=%b bcd=%h required 15/1/FFFF",
                  lat, bus_if.ovf, bus_if.bcd);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {4{SD}})
         $display("FAIL v10000_seg: got %b required %b", bus_if.segments, {4{SD}});
      else n_pass++;
   endtask

   task automatic test_ignore_start();
      int n_done;
      int first;
      n_done = 0;
      first  = -1;
      bus_if.value = 14'd705;
      bus_if.start = 1'b1;
      tick();
      for (int i = 1; i <= 30; i++) begin
         bus_if.start = (i == 5);
         bus_if.value = (i == 5) ? 14'd42 : 14'd705;
         tick();
         if (bus_if.done === 1'b1) begin
            n_done++;
            if (first < 0) first = i;
         end
      end
      bus_if.start = 1'b0;
      n_total++;
      if (n_done != 1 || first != 15)
         $display("FAIL ignore_done: pulses=%0d at=%0d required 1 at 15", n_done, first);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {SB, S7, S0, S5} || bus_if.bcd !== 16'h0705)
         $display("FAIL ignore_result: seg=%b bcd=%h required %b/0705",
                  bus_if.segments, bus_if.bcd, {SB, S7, S0, S5});
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int lat;
      int n_done;
      n_done = 0;
      bus_if.value = 14'd1234;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      for (int i = 1; i <= 7; i++) tick();
      rst_n = 1'b0;
      #1;
      n_total++;
      if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.ovf !== 1'b0)
         $display("FAIL abort_flags: busy=%b done=%b ovf=%b required 0/0/0",
                  bus_if.busy, bus_if.done, bus_if.ovf);
      else n_pass++;
      n_total++;
      if (bus_if.segments !== {4{SB}} || bus_if.bcd !== 16'h0000)
         $display("FAIL abort_outputs: seg=%b bcd=%h required blank/0000",
                  bus_if.segments, bus_if.bcd);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) rst_n = 1'b1;
         tick();
         if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) n_done++;
      end
      n_total++;
      if (n_done != 0 || bus_if.segments !== {4{SB}})
         $display("FAIL abort_quiet: activity=%0d seg=%b required 0/blank", n_done, bus_if.segments);
      else n_pass++;
      run_conv(14'd88, lat);
      n_total++;
      if (lat != 15 || bus_if.bcd !== 16'h0088 || bus_if.segments !== {SB, SB, S8, S8})
         $display("FAIL abort_v88: lat=%0d bcd=%h seg=%b required 15/0088/%b",
                  lat, bus_if.bcd, bus_if.segments, {SB, SB, S8, S8});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_bcd [3];
      logic [27:0] exp_seg [3];
      int          at      [3];
      int          n;
      exp_bcd[0] = 16'h0321;  exp_seg[0] = {SB, S3, S2, S1};
      exp_bcd[1] = 16'h4005;  exp_seg[1] = {S4, S0, S0, S5};
      exp_bcd[2] = 16'h0008;  exp_seg[2] = {SB, SB, SB, S8};
      n = 0;
      at[0] = -1;
      at[1] = -1;
      at[2] = -1;
      bus_if.value = 14'd321;
      bus_if.start = 1'b1;
      tick();
      bus_if.value = 14'd4005;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (i == 16) bus_if.value = 14'd8;
         if (i == 32) bus_if.start = 1'b0;
         if (bus_if.done === 1'b1) begin
            if (n < 3) begin
               at[n] = i;
               n_total++;
               if (bus_if.bcd !== exp_bcd[n] || bus_if.segments !== exp_seg[n])
                  $display("FAIL b2b_result%0d: bcd=%h seg=%b required %h/%b",
                           n, bus_if.bcd, bus_if.segments, exp_bcd[n], exp_seg[n]);
               else n_pass++;
            end
            n++;
         end
      end
      n_total++;
      if (n != 3 || at[0] != 15 || at[1] != 31 || at[2] != 47)
         $display("FAIL b2b_timing: pulses=%0d at %0d,%0d,%0d required 3 at 15,31,47",
                  n, at[0], at[1], at[2]);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_1234();
      test_zero();
      test_range_edge();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
